// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: carry chain cut into STAGES equal slices
// with a register boundary between slices and a single global advance for backpressure.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ovf
);

  localparam int unsigned STAGES_SAFE = (STAGES == 0) ? 1 : STAGES;
  localparam int unsigned W           = WIDTH / STAGES_SAFE;

  if ((STAGES == 0) || (STAGES > WIDTH) || ((WIDTH % STAGES_SAFE) != 0)) begin : g_param_check
    $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k consumes the lowest slice of the operands still in flight, appends its
  // slice to the sum collected so far, and forwards only the untouched upper operand bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM  = WIDTH - k * W;
    localparam int unsigned DONE = (k + 1) * W;

    logic [REM-1:0]  xa;
    logic [REM-1:0]  ya;
    logic            ca;
    logic            va;
    logic [W:0]      part;
    logic [DONE-1:0] sum_n;
    logic            vq;
    logic            cq;
    logic [DONE-1:0] sq;

    if (k == 0) begin : g_head
      assign xa    = X;
      assign ya    = sub ? ~Y : Y;
      assign ca    = sub | Ci;
      assign va    = in_valid;
      assign sum_n = part[W-1:0];
    end else begin : g_tail
      assign xa    = g_stage[k-1].g_ops.xq;
      assign ya    = g_stage[k-1].g_ops.yq;
      assign ca    = g_stage[k-1].cq;
      assign va    = g_stage[k-1].vq;
      assign sum_n = {part[W-1:0], g_stage[k-1].sq};
    end

    assign part = {1'b0, xa[W-1:0]} + {1'b0, ya[W-1:0]} + {{W{1'b0}}, ca};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vq <= 1'b0;
        cq <= 1'b0;
        sq <= '0;
      end else if (adv) begin
        vq <= va;
        cq <= part[W];
        sq <= sum_n;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [REM-W-1:0] xq;
      logic [REM-W-1:0] yq;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          xq <= '0;
          yq <= '0;
        end else if (adv) begin
          xq <= xa[REM-1:W];
          yq <= ya[REM-1:W];
        end
      end
    end

    if (k == STAGES - 1) begin : g_fin
      logic ovq;

      // Carry into the MSB is recovered as x^y^sum at that bit position.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovq <= 1'b0;
        end else if (adv) begin
          ovq <= part[W] ^ xa[W-1] ^ ya[W-1] ^ part[W-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vq;
  assign S         = g_stage[STAGES-1].sq;
  assign Co        = g_stage[STAGES-1].cq;
  assign Ovf       = g_stage[STAGES-1].g_fin.ovq;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: four instances (32/4, 8/1, 16/2, 64/8) share
// one stimulus stream and are checked against a handshake model with a whole-word adder.
module tb_pipelined_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        ci;
  logic        sub;
  logic [63:0] xb;
  logic [63:0] yb;

  logic        rdy  [4];
  logic        ov   [4];
  logic        oco  [4];
  logic        oovf [4];
  logic [63:0] os   [4];
  logic [31:0] s32;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [63:0] s64;

  int unsigned lat [4] = '{4, 1, 2, 8};
  int unsigned wid [4] = '{32, 8, 16, 64};

  logic        mv [4][8];
  logic [63:0] mx [4][8];
  logic [63:0] my [4][8];
  logic        mc [4][8];
  logic        ms [4][8];

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .X(xb[31:0]), .Y(yb[31:0]), .Ci(ci), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready), .S(s32), .Co(oco[0]), .Ovf(oovf[0]));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .X(xb[7:0]), .Y(yb[7:0]), .Ci(ci), .sub(sub),
    .out_valid(ov[1]), .out_ready(out_ready), .S(s8), .Co(oco[1]), .Ovf(oovf[1]));

  pipelined_adder #(.WIDTH(16), .STAGES(2)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .X(xb[15:0]), .Y(yb[15:0]), .Ci(ci), .sub(sub),
    .out_valid(ov[2]), .out_ready(out_ready), .S(s16), .Co(oco[2]), .Ovf(oovf[2]));

  pipelined_adder #(.WIDTH(64), .STAGES(8)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
    .X(xb), .Y(yb), .Ci(ci), .sub(sub),
    .out_valid(ov[3]), .out_ready(out_ready), .S(s64), .Co(oco[3]), .Ovf(oovf[3]));

  assign os[0] = {32'h0, s32};
  assign os[1] = {56'h0, s8};
  assign os[2] = {48'h0, s16};
  assign os[3] = s64;

  // Returns {ovf, co, sum}; overflow uses the operand/result sign rule.
  function automatic logic [65:0] ref_add(input int unsigned w, input logic [63:0] x, y,
                                          input logic c, sb);
    logic [63:0] mask;
    logic [63:0] xm;
    logic [63:0] ym;
    logic [64:0] full;
    logic [63:0] s;
    logic        co;
    logic        ovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    ym   = (sb ? ~y : y) & mask;
    full = {1'b0, xm} + {1'b0, ym} + {64'h0, sb | c};
    co   = full[w];
    s    = full[63:0] & mask;
    ovf  = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {ovf, co, s};
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 8; k++) mv[d][k] = 1'b0;
  endtask

  task automatic rnd();
    xb  = {$urandom, $urandom};
    yb  = {$urandom, $urandom};
    ci  = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Inputs are set by the caller just after an edge; checks ready, clocks once, checks outputs.
  task automatic cycle();
    logic        adv [4];
    logic [65:0] r;
    int unsigned last;
    #1;
    for (int d = 0; d < 4; d++) begin
      adv[d] = !mv[d][lat[d]-1] || out_ready;
      chk("in_ready", d, rdy[d], !rst_n || adv[d]);
    end
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (adv[d]) begin
          for (int k = 7; k > 0; k--) begin
            mv[d][k] = mv[d][k-1];
            mx[d][k] = mx[d][k-1];
            my[d][k] = my[d][k-1];
            mc[d][k] = mc[d][k-1];
            ms[d][k] = ms[d][k-1];
          end
          mv[d][0] = in_valid;
          mx[d][0] = xb;
          my[d][0] = yb;
          mc[d][0] = ci;
          ms[d][0] = sub;
        end
      end
    end
    #1;
    for (int d = 0; d < 4; d++) begin
      last = lat[d] - 1;
      if (!rst_n) begin
        chk("rst_valid", d, ov[d], 0);
        chk("rst_s", d, os[d], 0);
        chk("rst_co", d, oco[d], 0);
        chk("rst_ovf", d, oovf[d], 0);
      end else begin
        chk("out_valid", d, ov[d], mv[d][last]);
        if (mv[d][last]) begin
          r = ref_add(wid[d], mx[d][last], my[d][last], mc[d][last], ms[d][last]);
          chk("s", d, os[d], r[63:0]);
          chk("co", d, oco[d], r[64]);
          chk("ovf", d, oovf[d], r[65]);
        end
      end
    end
  endtask

  // Single 32-bit vector through the 4-stage instance with hand-computed results.
  task automatic one(input logic [31:0] x, y, input logic c, sb,
                     input logic [31:0] es, input logic eco, eovf);
    xb       = {32'h0, x};
    yb       = {32'h0, y};
    ci       = c;
    sub      = sb;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("dir_latency", 0, ov[0], 0);
    cycle();
    chk("dir_valid", 0, ov[0], 1);
    chk("dir_s", 0, os[0], {32'h0, es});
    chk("dir_co", 0, oco[0], eco);
    chk("dir_ovf", 0, oovf[0], eovf);
    cycle();
  endtask

  initial begin
    int  i;
    int  cyc;
    logic acc;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ci        = 1'b0;
    sub       = 1'b0;
    xb        = '0;
    yb        = '0;
    clear_model();

    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    one(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0);
    one(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    one(32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 1'b0, 1'b0);
    one(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    one(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    one(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    one(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0);
    repeat (8) cycle();

    for (int n = 0; n < 16; n++) begin
      rnd();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (9) cycle();

    i   = 0;
    cyc = 0;
    rnd();
    while (i < 16 && cyc < 60) begin
      out_ready = !(cyc >= 10 && cyc < 15);
      in_valid  = 1'b1;
      acc       = !mv[0][3] || out_ready;
      cycle();
      if (acc) begin
        i++;
        rnd();
      end
      cyc++;
    end
    chk("stall_accepted", 0, 64'(i), 64'd16);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) cycle();

    for (int n = 0; n < 12; n++) begin
      rnd();
      in_valid = (n % 2 == 0);
      cycle();
    end
    in_valid = 1'b0;
    repeat (9) cycle();

    for (int n = 0; n < 3; n++) begin
      rnd();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("async_valid", d, ov[d], 0);
      chk("async_s", d, os[d], 0);
      chk("async_co", d, oco[d], 0);
      chk("async_ovf", d, oovf[d], 0);
      chk("async_ready", d, rdy[d], 1);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
